// File: rtl/mem_req_responder.sv
// Memory-side responder for a four-phase req/ack read handshake.
// Returns the latched word a fixed number of cycles after acceptance; has a preload write port.
module mem_req_responder #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned DEPTH   = 196,
  parameter int unsigned LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              busy,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [15:0]       rd_count
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        lat_cnt_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic rd_in_range;
  logic wr_in_range;

  assign rd_in_range = addr_q < ADDR_W'(DEPTH);
  assign wr_in_range = wr_addr < ADDR_W'(DEPTH);
  assign busy        = (state_q != StIdle);

  // Storage is deliberately not reset so preloaded data survives rst.
  always_ff @(posedge clk) begin
    if (wr_en && wr_in_range) begin
      mem[wr_addr[IdxW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      lat_cnt_q <= '0;
      ack       <= 1'b0;
      err       <= 1'b0;
      rdata     <= '0;
      rd_count  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req) begin
            addr_q    <= addr;
            lat_cnt_q <= 4'(LATENCY - 1);
            state_q   <= StWait;
          end
        end
        StWait: begin
          if (!req) begin
            state_q <= StIdle;
          end else if (lat_cnt_q != 4'd0) begin
            lat_cnt_q <= lat_cnt_q - 4'd1;
          end else begin
            // Non-blocking read of mem gives read-before-write on a same-edge collision.
            ack     <= 1'b1;
            state_q <= StAck;
            if (rd_in_range) begin
              rdata <= mem[addr_q[IdxW-1:0]];
              err   <= 1'b0;
            end else begin
              rdata <= '0;
              err   <= 1'b1;
            end
            if (rd_count != 16'hFFFF) begin
              rd_count <= rd_count + 16'd1;
            end
          end
        end
        StAck: begin
          if (!req) begin
            ack     <= 1'b0;
            err     <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_req_responder.sv
// Directed bench for mem_req_responder: handshake latency, hold, abort, range errors,
// write collision and asynchronous reset.
module tb_mem_req_responder;

  localparam int unsigned LATENCY = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [11:0] addr;
  logic        ack;
  logic [31:0] rdata;
  logic        err;
  logic        busy;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [31:0] wr_data;
  logic [15:0] rd_count;

  int errors = 0;
  int checks = 0;
  int exp_count = 0;

  mem_req_responder #(
    .DATA_W (32),
    .ADDR_W (12),
    .DEPTH  (196),
    .LATENCY(LATENCY)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .addr    (addr),
    .ack     (ack),
    .rdata   (rdata),
    .err     (err),
    .busy    (busy),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_count(rd_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // All tasks are entered and left at a negedge.
  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Raises req and waits for ack; optionally writes coll_d to a on the capture edge.
  task automatic do_read(input logic [11:0] a, input logic [31:0] exp_d, input logic exp_e,
                         input bit coll, input logic [31:0] coll_d);
    int  cycles;
    bit  got;
    req    = 1'b1;
    addr   = a;
    cycles = 0;
    got    = 1'b0;
    while (!got && cycles < 20) begin
      @(negedge clk);
      cycles++;
      if (cycles == 1) chk("busy_wait", {31'd0, busy}, 32'd1);
      if (coll && cycles == LATENCY) begin
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = coll_d;
      end else begin
        wr_en = 1'b0;
      end
      if (ack) got = 1'b1;
    end
    chk("ack_seen", {31'd0, got}, 32'd1);
    chk("latency", 32'(cycles - 1), 32'(LATENCY));
    chk("rdata", rdata, exp_d);
    chk("err", {31'd0, err}, {31'd0, exp_e});
    if (exp_count < 16'hFFFF) exp_count++;
    chk("rd_count", {16'd0, rd_count}, 32'(exp_count));
  endtask

  task automatic release_req();
    req = 1'b0;
    @(negedge clk);
    chk("ack_drop", {31'd0, ack}, 32'd0);
    chk("err_drop", {31'd0, err}, 32'd0);
    chk("busy_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst     = 1'b1;
    req     = 1'b0;
    addr    = '0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    #1;
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_count", {16'd0, rd_count}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Preload.
    wr(12'd0, 32'h1000_0000);
    wr(12'd1, 32'h1111_1111);
    wr(12'd2, 32'h2222_2222);
    wr(12'd3, 32'h3333_3333);
    wr(12'd5, 32'hA5A5_0001);
    wr(12'd7, 32'h0000_0777);
    wr(12'd195, 32'hC3C3_0195);

    // 1: basic read.
    do_read(12'd5, 32'hA5A5_0001, 1'b0, 1'b0, '0);

    // 2: hold req while addr wanders; ack/rdata must not move.
    for (int i = 0; i < 5; i++) begin
      addr = 12'(i * 3);
      @(negedge clk);
      chk("hold_ack", {31'd0, ack}, 32'd1);
      chk("hold_rdata", rdata, 32'hA5A5_0001);
    end
    release_req();
    chk("rdata_kept", rdata, 32'hA5A5_0001);

    // 3: back-to-back sequential reads.
    do_read(12'd0, 32'h1000_0000, 1'b0, 1'b0, '0);
    release_req();
    do_read(12'd1, 32'h1111_1111, 1'b0, 1'b0, '0);
    release_req();
    do_read(12'd2, 32'h2222_2222, 1'b0, 1'b0, '0);
    release_req();
    do_read(12'd3, 32'h3333_3333, 1'b0, 1'b0, '0);
    release_req();

    // 4: range boundary and dropped out-of-range writes (261 would alias 5 if truncated).
    do_read(12'd196, 32'd0, 1'b1, 1'b0, '0);
    release_req();
    do_read(12'd195, 32'hC3C3_0195, 1'b0, 1'b0, '0);
    release_req();
    wr(12'd200, 32'hDEAD_BEEF);
    wr(12'd261, 32'hBAD0_0005);
    do_read(12'd200, 32'd0, 1'b1, 1'b0, '0);
    release_req();
    do_read(12'd5, 32'hA5A5_0001, 1'b0, 1'b0, '0);
    release_req();

    // 5: abort in WAIT.
    req  = 1'b1;
    addr = 12'd1;
    @(negedge clk);
    req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_ack", {31'd0, ack}, 32'd0);
    end
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_count", {16'd0, rd_count}, 32'(exp_count));

    // 5b: collision returns old word, next read returns new word.
    do_read(12'd7, 32'h0000_0777, 1'b0, 1'b1, 32'h0000_0888);
    release_req();
    do_read(12'd7, 32'h0000_0888, 1'b0, 1'b0, '0);

    // 6: async reset mid-ACK, observed before the next clock edge.
    #2;
    rst = 1'b1;
    #1;
    chk("arst_ack", {31'd0, ack}, 32'd0);
    chk("arst_err", {31'd0, err}, 32'd0);
    chk("arst_rdata", rdata, 32'd0);
    chk("arst_count", {16'd0, rd_count}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_count = 0;
    @(negedge clk);
    do_read(12'd5, 32'hA5A5_0001, 1'b0, 1'b0, '0);
    release_req();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
